// File: rtl/arm_imm_encoder_if.sv
// Request/result bundle for arm_imm_encoder: start/value in, busy/done/result out.
interface arm_imm_encoder_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SO_W   = 12;

  logic              start;
  logic [DATA_W-1:0] value;
  logic              busy;
  logic              done;
  logic              valid;
  logic [SO_W-1:0]   shift_operand;
  logic              inverted;

  modport master (
    output start, value,
    input  busy, done, valid, shift_operand, inverted
  );

  modport slave (
    input  start, value,
    output busy, done, valid, shift_operand, inverted
  );
endinterface

// File: rtl/arm_imm_encoder.sv
// Multi-cycle search for the ARM rotated-immediate encoding {rotate_imm, imm8} of a 32-bit value.
// Optional IMM_ENCODE_INVERT_EN also tries ~value (MVN/BIC form) at each rotation step.
module arm_imm_encoder #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  arm_imm_encoder_if.slave bus
);

  localparam int unsigned ROT_W = 4;
  localparam int unsigned IMM_W = 8;
  localparam int unsigned SO_W  = ROT_W + IMM_W;
  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(15);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_q, state_n;
  logic [DATA_WIDTH-1:0] work_q,  work_n;
  logic [ROT_W-1:0]      rot_q,   rot_n;
  logic                  busy_q,  busy_n;
  logic                  done_q,  done_n;
  logic                  valid_q, valid_n;
  logic [SO_W-1:0]       so_q,    so_n;
  logic                  direct_hit;
`ifdef IMM_ENCODE_INVERT_EN
  logic                  inv_q,   inv_n;
  logic                  inv_hit;
`endif

  // Remaining rotation must leave the whole value inside the low byte.
  assign direct_hit = (work_q[DATA_WIDTH-1:IMM_W] == '0);
`ifdef IMM_ENCODE_INVERT_EN
  assign inv_hit    = (work_q[DATA_WIDTH-1:IMM_W] == '1);
`endif

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      rot_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      so_q    <= '0;
`ifdef IMM_ENCODE_INVERT_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      work_q  <= work_n;
      rot_q   <= rot_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      valid_q <= valid_n;
      so_q    <= so_n;
`ifdef IMM_ENCODE_INVERT_EN
      inv_q   <= inv_n;
`endif
    end
  end

  // Next-state and next-output logic; one rotation evaluated per cycle.
  always_comb begin
    state_n = state_q;
    work_n  = work_q;
    rot_n   = rot_q;
    busy_n  = busy_q;
    done_n  = done_q;
    valid_n = valid_q;
    so_n    = so_q;
`ifdef IMM_ENCODE_INVERT_EN
    inv_n   = inv_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_n  = bus.value;
          rot_n   = '0;
          busy_n  = 1'b1;
          valid_n = 1'b0;
          so_n    = '0;
`ifdef IMM_ENCODE_INVERT_EN
          inv_n   = 1'b0;
`endif
          state_n = SEARCH;
        end
      end

      SEARCH: begin
        // Lowest rot tried first, so the first hit is the canonical encoding.
        if (direct_hit) begin
          so_n    = {rot_q, work_q[IMM_W-1:0]};
          valid_n = 1'b1;
          done_n  = 1'b1;
          state_n = DONE;
`ifdef IMM_ENCODE_INVERT_EN
        end else if (inv_hit) begin
          so_n    = {rot_q, ~work_q[IMM_W-1:0]};
          valid_n = 1'b1;
          inv_n   = 1'b1;
          done_n  = 1'b1;
          state_n = DONE;
`endif
        end else if (rot_q == ROT_LAST) begin
          so_n    = '0;
          valid_n = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          work_n  = {work_q[DATA_WIDTH-3:0], work_q[DATA_WIDTH-1:DATA_WIDTH-2]};
          rot_n   = rot_q + ROT_W'(1);
        end
      end

      DONE: begin
        done_n  = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: begin
        done_n  = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.valid         = valid_q;
  assign bus.shift_operand = so_q;
`ifdef IMM_ENCODE_INVERT_EN
  assign bus.inverted      = inv_q;
`else
  assign bus.inverted      = 1'b0;
`endif

  // Result strobe lasts exactly one cycle; an invalid result never carries a payload.
  a_done_one_cycle: assert property (@(posedge clk) disable iff (rst) done_q |=> !done_q);
  a_invalid_zero:   assert property (@(posedge clk) disable iff (rst) !valid_q |-> (so_q == '0));

endmodule
